// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// The output decode is kept here so the FSM and any reader agree on what each state drives.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_sup_state_e;

    localparam int DEF_RST_CYCLES   = 36;
    localparam int DEF_LOCK_TIMEOUT = 36000;
    localparam int DEF_LOCK_STABLE  = 360;
    localparam int DEF_LOSS_FILTER  = 4;
    localparam int DEF_MAX_RETRIES  = 3;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst_n;
        logic ready;
        logic fault;
    } pll_sup_outs_t;

    // Outputs are a pure function of the state being entered.
    function automatic pll_sup_outs_t decode_outputs(input pll_sup_state_e s);
        pll_sup_outs_t o;
        o.pll_rst   = (s == PLL_RST) || (s == FAULT);
        o.sys_rst_n = (s == RUN);
        o.ready     = (s == RUN);
        o.fault     = (s == FAULT);
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the lock supervisor (slave) and the logic that
// feeds it the PLL lock and consumes the reset/status outputs (master).
interface pll_sup_if
    import pll_sup_pkg::*;
#(
    parameter int MAX_RETRIES = DEF_MAX_RETRIES
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic               locked;
    logic               restart;
    logic               pll_rst;
    logic               sys_rst_n;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]         lock_loss_cnt;

    modport master (
        output locked, restart,
        input  pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  locked, restart,
        output pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the reference clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: non-blocking assignments make meta and q a true two-stage shift;
    // blocking ones would collapse them into a single flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock, releases the
// system reset once lock is stable, and retries or faults when lock never settles.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input logic      refclk,
    input logic      rst_n,
    pll_sup_if.slave bus
);
    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W   = $clog2(LOCK_STABLE + 1);
    localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(LOCK_STABLE - 1);
    localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

    logic               locked_s;
    pll_sup_state_e     state;
    pll_sup_outs_t      outs;
    logic [RST_W-1:0]   rst_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [STB_W-1:0]   stable_cnt;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]         lock_loss_cnt;

    sync_2ff u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state         <= PLL_RST;
            outs          <= decode_outputs(PLL_RST);
            rst_cnt       <= '0;
            tmo_cnt       <= '0;
            stable_cnt    <= '0;
            loss_cnt      <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else if (bus.restart) begin
            // Overrides any loss or timeout detected on this edge; neither is counted.
            state     <= PLL_RST;
            outs      <= decode_outputs(PLL_RST);
            rst_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            case (state)
                PLL_RST: begin
                    tmo_cnt <= '0;
                    if (rst_cnt == RST_LAST) begin
                        state      <= WAIT_LOCK;
                        outs       <= decode_outputs(WAIT_LOCK);
                        rst_cnt    <= '0;
                        stable_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end

                // stable_cnt is the run of consecutive locked_s=1 cycles; the
                // WAIT_LOCK->STABLE edge is the first cycle of that run.
                WAIT_LOCK, STABLE: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt == RETRY_LAST) begin
                            state <= FAULT;
                            outs  <= decode_outputs(FAULT);
                        end else begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= PLL_RST;
                            outs      <= decode_outputs(PLL_RST);
                        end
                    end else if (!locked_s) begin
                        stable_cnt <= '0;
                        state      <= WAIT_LOCK;
                        outs       <= decode_outputs(WAIT_LOCK);
                    end else if (stable_cnt == STB_LAST) begin
                        retry_cnt <= '0;
                        loss_cnt  <= '0;
                        state     <= RUN;
                        outs      <= decode_outputs(RUN);
                    end else begin
                        stable_cnt <= stable_cnt + STB_W'(1);
                        state      <= STABLE;
                        outs       <= decode_outputs(STABLE);
                    end
                end

                RUN: begin
                    if (locked_s) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                        loss_cnt <= '0;
                        state    <= PLL_RST;
                        outs     <= decode_outputs(PLL_RST);
                    end else begin
                        loss_cnt <= loss_cnt + LOSS_W'(1);
                    end
                end

                FAULT: begin
                    state <= FAULT;
                end

                default: begin
                    state   <= PLL_RST;
                    outs    <= decode_outputs(PLL_RST);
                    rst_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.pll_rst       = outs.pll_rst;
    assign bus.sys_rst_n     = outs.sys_rst_n;
    assign bus.ready         = outs.ready;
    assign bus.fault         = outs.fault;
    assign bus.retry_cnt     = retry_cnt;
    assign bus.lock_loss_cnt = lock_loss_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: scenario tasks with inline checks
// against a behavioural model of the supervisor's rules.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int LOSS_FILTER  = 3;
    localparam int MAX_RETRIES  = 2;

    logic refclk = 1'b0;
    logic rst_n;

    pll_sup_if #(.MAX_RETRIES(MAX_RETRIES)) bus ();

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOSS_FILTER  (LOSS_FILTER),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 refclk = ~refclk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;   // cycle index since the last reset edge

    // Behavioural model: PLL reset pulse, lock acquisition, running, fault.
    typedef enum int {M_RST, M_ACQ, M_RUN, M_FAULT} mode_e;
    mode_e m_mode = M_RST;
    int m_elapsed, m_tmo, m_lock_run, m_unlock_run, m_retries, m_losses;
    bit m_sync[$];

    function automatic void model_edge(input bit lk, input bit rs, input bit rn);
        bit seen;
        if (!rn) begin
            m_mode = M_RST;
            m_elapsed = 0; m_tmo = 0; m_lock_run = 0; m_unlock_run = 0;
            m_retries = 0; m_losses = 0;
            m_sync.delete();
            m_sync.push_back(1'b0);
            m_sync.push_back(1'b0);
            return;
        end
        seen = m_sync.pop_back();
        m_sync.push_front(lk);
        if (rs) begin
            m_mode = M_RST; m_elapsed = 0; m_retries = 0;
            return;
        end
        case (m_mode)
            M_RST: begin
                m_elapsed++;
                if (m_elapsed == RST_CYCLES) begin
                    m_mode = M_ACQ; m_tmo = 0; m_lock_run = 0;
                end
            end
            M_ACQ: begin
                m_tmo++;
                m_lock_run = seen ? m_lock_run + 1 : 0;
                if (m_tmo == LOCK_TIMEOUT) begin
                    if (m_retries == MAX_RETRIES) m_mode = M_FAULT;
                    else begin
                        m_retries++; m_mode = M_RST; m_elapsed = 0;
                    end
                end else if (m_lock_run == LOCK_STABLE) begin
                    m_mode = M_RUN; m_retries = 0; m_unlock_run = 0;
                end
            end
            M_RUN: begin
                m_unlock_run = seen ? 0 : m_unlock_run + 1;
                if (m_unlock_run == LOSS_FILTER) begin
                    if (m_losses < 255) m_losses++;
                    m_mode = M_RST; m_elapsed = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [13:0] exp_vec();
        return {(m_mode == M_RST) || (m_mode == M_FAULT), m_mode == M_RUN, m_mode == M_RUN,
                m_mode == M_FAULT, 2'(m_retries), 8'(m_losses)};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.retry_cnt, bus.lock_loss_cnt};
    endfunction

    // Drive one cycle of inputs, advance the model on the same edge, sample on the falling edge.
    task automatic tick(input bit lk, input bit rs, input bit rn);
        bus.locked  = lk;
        bus.restart = rs;
        rst_n       = rn;
        @(posedge refclk);
        model_edge(lk, rs, rn);
        @(negedge refclk);
        cyc = rn ? cyc + 1 : 0;
    endtask

    task automatic reach_run();
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        repeat (24) tick(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        tests++;
        if (obs_vec() !== 14'h2000) begin
            fails++;
            $display("FAIL reset_values got=%h expected=%h", obs_vec(), 14'h2000);
        end
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model got=%h expected=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic run_bring_up(input string tag);
        logic exp_pr, exp_up;
        for (int c = 0; c < 24; c++) begin
            tick(c >= 10, 1'b0, 1'b1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL %s_model cyc=%0d got=%h expected=%h", tag, cyc, obs_vec(), exp_vec());
            end
            exp_pr = (cyc < RST_CYCLES);
            exp_up = (cyc >= 20);
            tests++;
            if ({bus.pll_rst, bus.sys_rst_n, bus.ready} !== {exp_pr, exp_up, exp_up}) begin
                fails++;
                $display("FAIL %s_timing cyc=%0d got=%b expected=%b", tag, cyc,
                         {bus.pll_rst, bus.sys_rst_n, bus.ready}, {exp_pr, exp_up, exp_up});
            end
        end
        tests++;
        if (bus.retry_cnt !== 2'd0) begin
            fails++;
            $display("FAIL %s_retry got=%0d expected=0", tag, bus.retry_cnt);
        end
    endtask

    task automatic test_bring_up();
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        run_bring_up("bring_up");
    endtask

    task automatic test_no_lock();
        logic       exp_pr, exp_ft;
        logic [1:0] exp_rc;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 80; c++) begin
            tick(1'b0, 1'b0, 1'b1);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL no_lock_model cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            exp_pr = ((cyc % 24) < 4) || (cyc >= 72);
            exp_ft = (cyc >= 72);
            exp_rc = (cyc < 24) ? 2'd0 : (cyc < 48) ? 2'd1 : 2'd2;
            tests++;
            if ({bus.pll_rst, bus.fault, bus.retry_cnt} !== {exp_pr, exp_ft, exp_rc}) begin
                fails++;
                $display("FAIL no_lock_seq cyc=%0d got=%b expected=%b", cyc,
                         {bus.pll_rst, bus.fault, bus.retry_cnt}, {exp_pr, exp_ft, exp_rc});
            end
        end
    endtask

    task automatic test_glitch_filter();
        int         t, glitch;
        logic       exp_pr, exp_up;
        logic [7:0] exp_loss;
        reach_run();
        repeat ($urandom_range(0, 5)) tick(1'b1, 1'b0, 1'b1);
        glitch = $urandom_range(1, LOSS_FILTER - 1);
        for (int k = 0; k < glitch + 10; k++) begin
            tick(k >= glitch, 1'b0, 1'b1);
            tests++;
            if ({bus.ready, bus.sys_rst_n, bus.pll_rst, bus.lock_loss_cnt} !== {3'b110, 8'd0}) begin
                fails++;
                $display("FAIL glitch_hold cyc=%0d got=%b expected=%b", cyc,
                         {bus.ready, bus.sys_rst_n, bus.pll_rst, bus.lock_loss_cnt}, {3'b110, 8'd0});
            end
        end
        t = cyc;
        for (int k = 0; k < 28; k++) begin
            tick(k >= LOSS_FILTER, 1'b0, 1'b1);
            exp_pr   = (cyc >= t + 5) && (cyc < t + 9);
            exp_up   = !((cyc >= t + 5) && (cyc < t + 17));
            exp_loss = (cyc >= t + 5) ? 8'd1 : 8'd0;
            tests++;
            if ({bus.pll_rst, bus.sys_rst_n, bus.lock_loss_cnt} !== {exp_pr, exp_up, exp_loss}) begin
                fails++;
                $display("FAIL loss_timing cyc=%0d t=%0d got=%b expected=%b", cyc, t,
                         {bus.pll_rst, bus.sys_rst_n, bus.lock_loss_cnt}, {exp_pr, exp_up, exp_loss});
            end
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL loss_model cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_chatter();
        int         ph;
        logic [1:0] exp_rc;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        ph = $urandom_range(0, 9);
        for (int c = 0; c < 40; c++) begin
            tick(((c + ph) / 5) % 2 == 0, 1'b0, 1'b1);
            exp_rc = (cyc >= 24) ? 2'd1 : 2'd0;
            tests++;
            if ({bus.ready, bus.sys_rst_n, bus.retry_cnt} !== {2'b00, exp_rc}) begin
                fails++;
                $display("FAIL chatter cyc=%0d ph=%0d got=%b expected=%b", cyc, ph,
                         {bus.ready, bus.sys_rst_n, bus.retry_cnt}, {2'b00, exp_rc});
            end
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL chatter_model cyc=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        int   s, t;
        logic exp_pr, exp_up;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        repeat (73) tick(1'b0, 1'b0, 1'b1);
        tests++;
        if ({bus.fault, bus.retry_cnt, bus.pll_rst} !== {1'b1, 2'd2, 1'b1}) begin
            fails++;
            $display("FAIL fault_entry got=%b expected=%b", {bus.fault, bus.retry_cnt, bus.pll_rst}, 4'b1101);
        end
        s = cyc;
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, k == 0, 1'b1);
            exp_pr = (cyc <= s + 4);
            tests++;
            if ({bus.pll_rst, bus.fault, bus.retry_cnt} !== {exp_pr, 1'b0, 2'd0}) begin
                fails++;
                $display("FAIL restart_fault cyc=%0d got=%b expected=%b", cyc,
                         {bus.pll_rst, bus.fault, bus.retry_cnt}, {exp_pr, 3'b000});
            end
        end
        reach_run();
        t = cyc;
        for (int k = 0; k < 12; k++) begin
            tick(k >= LOSS_FILTER, k == 4, 1'b1);
            exp_pr = (cyc >= t + 5) && (cyc < t + 9);
            exp_up = (cyc < t + 5);
            tests++;
            if ({bus.pll_rst, bus.ready, bus.lock_loss_cnt} !== {exp_pr, exp_up, 8'd0}) begin
                fails++;
                $display("FAIL restart_vs_loss cyc=%0d got=%b expected=%b", cyc,
                         {bus.pll_rst, bus.ready, bus.lock_loss_cnt}, {exp_pr, exp_up, 8'd0});
            end
        end
    endtask

    task automatic test_reset_mid_op();
        reach_run();
        repeat ($urandom_range(1, 6)) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tests++;
        if (obs_vec() !== 14'h2000) begin
            fails++;
            $display("FAIL mid_reset_values got=%h expected=%h", obs_vec(), 14'h2000);
        end
        run_bring_up("rebring_up");
    endtask

    task automatic test_loss_saturation();
        reach_run();
        for (int n = 0; n < 258; n++) begin
            for (int k = 0; k < 23; k++) begin
                tick(k >= LOSS_FILTER, 1'b0, 1'b1);
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL sat_model n=%0d cyc=%0d got=%h expected=%h", n, cyc, obs_vec(), exp_vec());
                end
            end
        end
        tests++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            fails++;
            $display("FAIL loss_saturation got=%0d expected=255", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_random();
        bit lk   = 1'b0;
        int hold = 0;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            bit rs, rn;
            if (hold == 0) begin
                lk   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 30);
            end
            hold--;
            rs = ($urandom_range(0, 79) == 0);
            rn = ($urandom_range(0, 399) != 0);
            tick(lk, rs, rn);
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random_model i=%0d got=%h expected=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.locked  = 1'b0;
        bus.restart = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_bring_up();
        test_no_lock();
        test_glitch_filter();
        test_chatter();
        test_restart();
        test_reset_mid_op();
        test_loss_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset and lock supervisor that sits directly downstream of the 125 MHz three-output PLL wrapper. It drives the PLL reset, filters and synchronises the PLL `locked` output, and withholds the system reset until lock has been stable. It re-initialises the PLL on lock loss or lock timeout, and latches a fault after repeated failures. It runs on the PLL reference clock, which stays alive while the PLL is unlocked.

## Interface
Parameters:
- `RST_CYCLES`, 36: cycles `pll_rst` is held high per PLL reset pulse (100 ns at 360 MHz).
- `LOCK_TIMEOUT`, 36000: cycles allowed from PLL reset release to reaching RUN.
- `LOCK_STABLE`, 360: consecutive synchronised-lock cycles required before release.
- `LOSS_FILTER`, 4: consecutive unlocked cycles in RUN that count as lock loss.
- `MAX_RETRIES`, 3: timeout retries allowed before FAULT.

Ports:
- `refclk`, in, 1: the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `locked`, in, 1: PLL lock; asynchronous to `refclk`.
- `restart`, in, 1: single-cycle soft re-initialise request.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `sys_rst_n`, out, 1: active-low reset for the `outclk_*` domains. Each consumer re-synchronises it locally.
- `ready`, out, 1: high in RUN only.
- `fault`, out, 1: sticky retry-exhaustion flag.
- `retry_cnt`, out, `$clog2(MAX_RETRIES+1)`: timeouts since the last RUN or restart.
- `lock_loss_cnt`, out, 8: lock-loss events, saturating at 255.

## Operation
- `locked` passes through a 2-flop synchroniser to give `locked_s`, adding 2 cycles of latency.
- States:
  - **PLL_RST**: `pll_rst`=1 for exactly `RST_CYCLES` cycles; clears the timeout counter; then goes to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0. Goes to STABLE on `locked_s`=1.
  - **STABLE**: any `locked_s`=0 cycle returns to WAIT_LOCK and clears the stable counter. After `LOCK_STABLE` consecutive `locked_s`=1 cycles, goes to RUN.
  - **RUN**: `sys_rst_n`=1, `ready`=1, `retry_cnt` cleared. After `LOSS_FILTER` consecutive `locked_s`=0 cycles: increment `lock_loss_cnt` (saturating), go to PLL_RST. A lock loss does not increment `retry_cnt`.
  - **FAULT**: `pll_rst`=1, `fault`=1, `sys_rst_n`=0. Exits only via `restart` or `rst_n`.
- The timeout counter runs in both WAIT_LOCK and STABLE; STABLE bounces do not clear it. When it reaches `LOCK_TIMEOUT`:
  - if `retry_cnt`==`MAX_RETRIES`, go to FAULT;
  - otherwise increment `retry_cnt` and go to PLL_RST.
- `restart`=1 in any state goes to PLL_RST and clears `retry_cnt` and `fault`. `lock_loss_cnt` is kept. `restart` has priority over every other transition, including a lock loss or timeout in the same cycle; that loss or timeout is not counted.
- Priority order: `rst_n` > `restart` > timeout/loss > normal progression.
- All counters saturate or compare with `==`; none wraps.

## Timing
- Outputs are registered and decoded from the next state, so each output changes on the same edge as its state transition.
- While `rst_n`=0, on the next edge:
  - state = PLL_RST, all counters 0, synchroniser flops 0;
  - `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0;
  - `retry_cnt`=0, `lock_loss_cnt`=0.
- Cycle 0 is the first cycle with `rst_n`=1. `pll_rst` is high for cycles 0..`RST_CYCLES`-1 and low from cycle `RST_CYCLES`.
- If `locked` is first sampled high at cycle t and held, `sys_rst_n` and `ready` rise at cycle t+2+`LOCK_STABLE`.
- If `locked` is first sampled low at cycle t in RUN and held, `sys_rst_n` falls and `pll_rst` rises at cycle t+2+`LOSS_FILTER`.
- `sys_rst_n` never rises while `pll_rst`=1.

## Structure
- Package `pll_sup_pkg`: state enum `pll_sup_state_e` {PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT}, plus default parameter constants.
- Sub-module `sync_2ff`: a 2-flop synchroniser for `locked`, reset to 0 by `rst_n`.

## Test plan
All scenarios use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `LOSS_FILTER`=3, `MAX_RETRIES`=2.
- Clean bring-up: release reset at cycle 0, `locked` rises at cycle 10 -> `pll_rst` falls at cycle 4; `sys_rst_n`=`ready`=1 at cycle 20; `retry_cnt`=0.
- No lock: `locked` held 0 -> three 4-cycle `pll_rst` pulses (initial plus 2 retries); after the third timeout `fault`=1, `retry_cnt`=2, `pll_rst` stuck at 1.
- Glitch filter in RUN: `locked` low for 2 cycles -> no output change. Low for 3 cycles -> `sys_rst_n` falls at +5, `lock_loss_cnt`=1, 4-cycle `pll_rst` pulse, then re-lock to RUN.
- Chatter in STABLE: `locked` toggles every 5 cycles -> never reaches RUN; timeout at 20 cycles -> `retry_cnt`=1.
- Restart: `restart` pulse in FAULT -> `fault`=0, `retry_cnt`=0, 4-cycle `pll_rst`. `restart` in the same cycle as a RUN lock-loss detection -> PLL_RST, `lock_loss_cnt` unchanged.
- Reset mid-operation: `rst_n`=0 for one cycle in RUN -> all outputs at reset values on the next edge; the bring-up sequence repeats exactly.
